id_ex_stage: RTL and testbench

ID/EX pipeline stage of the five-stage MIPS core. It registers the decoded control bundle, operands and register specifiers from ID for use in EX. It feeds `ex_aluop` and `ex_funct` straight into the ALU-control decoder and the ALU. It also contains the load-use hazard detector, which freezes PC and IF/ID and injects a bubble, and a saturating bubble counter.

---
 rtl/ve370_pkg.sv | 28 ++
 rtl/hazard_detect.sv | 30 +++
 rtl/id_ex_stage.sv | 128 ++++++++++++
 tb/tb_id_ex_stage.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ve370_pkg.sv
// Shared constants and types for the five-stage MIPS core.
// ALU opcode/funct encodings and the EX control bundle.
package ve370_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_AND   = 2'b11;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam int CTRL_W = 8;

  typedef struct packed {
    logic       regwrite;
    logic       memtoreg;
    logic       memread;
    logic       memwrite;
    logic       regdst;
    logic       alusrc;
    logic [1:0] aluop;
  } ctrl_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector for the ID/EX boundary.
// Purely combinational; freezes PC and IF/ID while a load feeds ID.
module hazard_detect
  import ve370_pkg::*;
(
  input  logic       id_valid,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       ex_valid,
  input  logic       ex_memread,
  input  logic [4:0] ex_rt,
  output logic       hz,
  output logic       pc_write,
  output logic       ifid_write
);

  logic rt_nz;
  logic rt_hit;

  // Register $zero never carries a real dependency.
  always_comb begin
    rt_nz  = (ex_rt != 5'd0);
    rt_hit = (ex_rt == id_rs) | (ex_rt == id_rt);
    hz     = id_valid & ex_valid & ex_memread
           & rt_nz & rt_hit;
    pc_write   = ~hz;
    ifid_write = ~hz;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble injection.
// Also counts inserted bubbles in a saturating counter.
module id_ex_stage
  import ve370_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             id_valid,
  input  logic             id_regwrite,
  input  logic             id_memtoreg,
  input  logic             id_memread,
  input  logic             id_memwrite,
  input  logic             id_regdst,
  input  logic             id_alusrc,
  input  logic [1:0]       id_aluop,
  input  logic [31:0]      id_rd1,
  input  logic [31:0]      id_rd2,
  input  logic [31:0]      id_imm,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       id_rd,
  output logic             ex_valid,
  output logic             ex_regwrite,
  output logic             ex_memtoreg,
  output logic             ex_memread,
  output logic             ex_memwrite,
  output logic             ex_regdst,
  output logic             ex_alusrc,
  output logic [1:0]       ex_aluop,
  output logic [5:0]       ex_funct,
  output logic [31:0]      ex_rd1,
  output logic [31:0]      ex_rd2,
  output logic [31:0]      ex_imm,
  output logic [4:0]       ex_rs,
  output logic [4:0]       ex_rt,
  output logic [4:0]       ex_rd,
  output logic             pc_write,
  output logic             ifid_write,
  output logic [CNT_W-1:0] bubble_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  ctrl_t id_ctrl;
  ctrl_t ex_ctrl;
  logic  hz;
  logic  bubble;
  logic  count;

  hazard_detect u_hz (
    .id_valid   (id_valid),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .ex_valid   (ex_valid),
    .ex_memread (ex_ctrl.memread),
    .ex_rt      (ex_rt),
    .hz         (hz),
    .pc_write   (pc_write),
    .ifid_write (ifid_write)
  );

  // Pack ID control and decide whether this edge injects a bubble.
  always_comb begin
    id_ctrl.regwrite = id_regwrite;
    id_ctrl.memtoreg = id_memtoreg;
    id_ctrl.memread  = id_memread;
    id_ctrl.memwrite = id_memwrite;
    id_ctrl.regdst   = id_regdst;
    id_ctrl.alusrc   = id_alusrc;
    id_ctrl.aluop    = id_aluop;
    bubble = hz | flush | ~id_valid;
    count  = hz | flush;
  end

  // Pipeline register: data always loads, control zeroed on a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid <= 1'b0;
      ex_ctrl  <= '0;
      ex_rd1   <= '0;
      ex_rd2   <= '0;
      ex_imm   <= '0;
      ex_rs    <= '0;
      ex_rt    <= '0;
      ex_rd    <= '0;
    end else begin
      ex_rd1 <= id_rd1;
      ex_rd2 <= id_rd2;
      ex_imm <= id_imm;
      ex_rs  <= id_rs;
      ex_rt  <= id_rt;
      ex_rd  <= id_rd;
      if (bubble) begin
        ex_valid <= 1'b0;
        ex_ctrl  <= '0;
      end else begin
        ex_valid <= 1'b1;
        ex_ctrl  <= id_ctrl;
      end
    end
  end

  // Saturating count of hazard/flush bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt <= '0;
    end else if (count && bubble_cnt != CNT_MAX) begin
      bubble_cnt <= bubble_cnt + CNT_ONE;
    end
  end

  // Unpack the registered bundle onto the EX-side ports.
  always_comb begin
    ex_regwrite = ex_ctrl.regwrite;
    ex_memtoreg = ex_ctrl.memtoreg;
    ex_memread  = ex_ctrl.memread;
    ex_memwrite = ex_ctrl.memwrite;
    ex_regdst   = ex_ctrl.regdst;
    ex_alusrc   = ex_ctrl.alusrc;
    ex_aluop    = ex_ctrl.aluop;
    ex_funct    = ex_imm[5:0];
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage.
// A CNT_W=4 twin shares the stimulus to exercise saturation.
module tb_id_ex_stage;
  import ve370_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        id_valid;
  logic        id_regwrite, id_memtoreg, id_memread;
  logic        id_memwrite, id_regdst, id_alusrc;
  logic [1:0]  id_aluop;
  logic [31:0] id_rd1, id_rd2, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;

  logic        ex_valid, ex_regwrite, ex_memtoreg, ex_memread;
  logic        ex_memwrite, ex_regdst, ex_alusrc;
  logic [1:0]  ex_aluop;
  logic [5:0]  ex_funct;
  logic [31:0] ex_rd1, ex_rd2, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic        pc_write, ifid_write;
  logic [31:0] bubble_cnt;

  logic        s_valid, s_regwrite, s_memtoreg, s_memread;
  logic        s_memwrite, s_regdst, s_alusrc;
  logic [1:0]  s_aluop;
  logic [5:0]  s_funct;
  logic [31:0] s_rd1, s_rd2, s_imm;
  logic [4:0]  s_rs, s_rt, s_rd;
  logic        s_pc_write, s_ifid_write;
  logic [3:0]  s_cnt;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .id_valid(id_valid), .id_regwrite(id_regwrite),
    .id_memtoreg(id_memtoreg), .id_memread(id_memread),
    .id_memwrite(id_memwrite), .id_regdst(id_regdst),
    .id_alusrc(id_alusrc), .id_aluop(id_aluop),
    .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .ex_valid(ex_valid), .ex_regwrite(ex_regwrite),
    .ex_memtoreg(ex_memtoreg), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .ex_regdst(ex_regdst),
    .ex_alusrc(ex_alusrc), .ex_aluop(ex_aluop),
    .ex_funct(ex_funct), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2),
    .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_rd(ex_rd), .pc_write(pc_write),
    .ifid_write(ifid_write), .bubble_cnt(bubble_cnt)
  );

  id_ex_stage #(.CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .id_valid(id_valid), .id_regwrite(id_regwrite),
    .id_memtoreg(id_memtoreg), .id_memread(id_memread),
    .id_memwrite(id_memwrite), .id_regdst(id_regdst),
    .id_alusrc(id_alusrc), .id_aluop(id_aluop),
    .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .ex_valid(s_valid), .ex_regwrite(s_regwrite),
    .ex_memtoreg(s_memtoreg), .ex_memread(s_memread),
    .ex_memwrite(s_memwrite), .ex_regdst(s_regdst),
    .ex_alusrc(s_alusrc), .ex_aluop(s_aluop),
    .ex_funct(s_funct), .ex_rd1(s_rd1), .ex_rd2(s_rd2),
    .ex_imm(s_imm), .ex_rs(s_rs), .ex_rt(s_rt),
    .ex_rd(s_rd), .pc_write(s_pc_write),
    .ifid_write(s_ifid_write), .bubble_cnt(s_cnt)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // R-type instruction in ID.
  task automatic drv_r(input logic [4:0] rs,
                       input logic [4:0] rt,
                       input logic [4:0] rd,
                       input logic [5:0] fn);
    id_valid    = 1'b1;
    id_regwrite = 1'b1;
    id_memtoreg = 1'b0;
    id_memread  = 1'b0;
    id_memwrite = 1'b0;
    id_regdst   = 1'b1;
    id_alusrc   = 1'b0;
    id_aluop    = ALUOP_RTYPE;
    id_imm      = {26'd0, fn};
    id_rs = rs; id_rt = rt; id_rd = rd;
  endtask

  // lw rt, imm(rs) in ID.
  task automatic drv_lw(input logic [4:0] rs,
                        input logic [4:0] rt);
    id_valid    = 1'b1;
    id_regwrite = 1'b1;
    id_memtoreg = 1'b1;
    id_memread  = 1'b1;
    id_memwrite = 1'b0;
    id_regdst   = 1'b0;
    id_alusrc   = 1'b1;
    id_aluop    = ALUOP_ADD;
    id_imm      = 32'h0000_0004;
    id_rs = rs; id_rt = rt; id_rd = 5'd0;
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    id_valid = 1'b0;
    id_regwrite = 1'b0; id_memtoreg = 1'b0;
    id_memread = 1'b0;  id_memwrite = 1'b0;
    id_regdst = 1'b0;   id_alusrc = 1'b0;
    id_aluop = 2'b00;
    id_rd1 = '0; id_rd2 = '0; id_imm = '0;
    id_rs = '0; id_rt = '0; id_rd = '0;

    #3;
    chk("rst_valid", ex_valid, 0);
    chk("rst_cnt", bubble_cnt, 0);
    chk("rst_pcw", pc_write, 1);
    chk("rst_ifw", ifid_write, 1);

    // R-type add
    @(negedge clk);
    rst_n = 1'b1;
    drv_r(5'd1, 5'd2, 5'd3, FUNCT_ADD);
    id_rd1 = 32'h1111_1111;
    id_rd2 = 32'h2222_2222;
    tick();
    chk("r_aluop", ex_aluop, 2'b10);
    chk("r_funct", ex_funct, 6'h20);
    chk("r_regwr", ex_regwrite, 1);
    chk("r_valid", ex_valid, 1);
    chk("r_cnt", bubble_cnt, 0);
    chk("r_rd1", ex_rd1, 32'h1111_1111);
    chk("r_rd", ex_rd, 3);

    // Load-use on $8
    drv_lw(5'd1, 5'd8);
    tick();
    chk("lw_memrd", ex_memread, 1);
    drv_r(5'd8, 5'd2, 5'd4, FUNCT_SUB);
    #1;
    chk("lu_pcw", pc_write, 0);
    chk("lu_ifw", ifid_write, 0);
    tick();
    chk("lu_bvalid", ex_valid, 0);
    chk("lu_bmemrd", ex_memread, 0);
    chk("lu_baluop", ex_aluop, 0);
    chk("lu_cnt", bubble_cnt, 1);
    chk("lu_pcw2", pc_write, 1);
    tick();
    chk("lu_dvalid", ex_valid, 1);
    chk("lu_dfunct", ex_funct, 6'h22);
    chk("lu_cnt2", bubble_cnt, 1);

    // lw to $0, then a use of $0
    drv_lw(5'd1, 5'd0);
    tick();
    drv_lw(5'd0, 5'd9);
    #1;
    chk("z_pcw", pc_write, 1);
    tick();
    chk("z_valid", ex_valid, 1);
    chk("z_rt", ex_rt, 9);
    chk("z_cnt", bubble_cnt, 1);

    // lw $9, then an instruction using only $10
    drv_r(5'd10, 5'd10, 5'd11, FUNCT_OR);
    #1;
    chk("nd_pcw", pc_write, 1);
    tick();
    chk("nd_valid", ex_valid, 1);
    chk("nd_cnt", bubble_cnt, 1);

    // Flush coincident with a hazard
    drv_lw(5'd1, 5'd5);
    tick();
    drv_r(5'd5, 5'd6, 5'd7, FUNCT_AND);
    flush = 1'b1;
    #1;
    chk("fh_pcw", pc_write, 0);
    tick();
    flush = 1'b0;
    chk("fh_valid", ex_valid, 0);
    chk("fh_regwr", ex_regwrite, 0);
    chk("fh_cnt", bubble_cnt, 2);
    #1;
    chk("fh_pcw2", pc_write, 1);

    // Invalid ID slot alone does not count
    id_valid = 1'b0;
    tick();
    chk("iv_valid", ex_valid, 0);
    chk("iv_cnt", bubble_cnt, 2);

    // Saturation: 20 flush edges from a count of 2
    drv_r(5'd1, 5'd2, 5'd3, FUNCT_SLT);
    flush = 1'b1;
    #1;
    chk("fl_pcw", pc_write, 1);
    for (int i = 0; i < 20; i++) tick();
    flush = 1'b0;
    chk("sat_cnt", s_cnt, 15);
    chk("wide_cnt", bubble_cnt, 22);
    tick();
    chk("sat_hold", s_cnt, 15);

    // Asynchronous reset during a stall
    drv_lw(5'd1, 5'd7);
    tick();
    drv_r(5'd7, 5'd2, 5'd3, FUNCT_ADD);
    #1;
    chk("ar_pcw0", pc_write, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", ex_valid, 0);
    chk("ar_memrd", ex_memread, 0);
    chk("ar_rd1", ex_rd1, 0);
    chk("ar_cnt", bubble_cnt, 0);
    chk("ar_pcw", pc_write, 1);
    #1;
    rst_n = 1'b1;
    id_rd1 = 32'hDEAD_BEEF;
    tick();
    chk("rr_valid", ex_valid, 1);
    chk("rr_rd1", ex_rd1, 32'hDEAD_BEEF);
    chk("rr_cnt", bubble_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_miss);
    $finish;
  end

endmodule
